// File: rtl/wave_meter_if.sv
// Measurement bundle between the wave meter and its consumer.
// The meter drives the results; the consumer supplies the wave.
interface wave_meter_if #(
  parameter int W = 4
);
  logic         wave_in;
  logic [W-1:0] on_us;
  logic [W-1:0] off_us;
  logic         valid;
  logic         locked;
  logic         ovf;

  modport master (
    input  wave_in,
    output on_us,
    output off_us,
    output valid,
    output locked,
    output ovf
  );

  modport slave (
    output wave_in,
    input  on_us,
    input  off_us,
    input  valid,
    input  locked,
    input  ovf
  );
endinterface

// File: rtl/wave_meter.sv
// Square-wave meter: measures high/low time of each period in us
// and publishes them on every rise that closes a full period.
module wave_meter #(
  parameter int CLK_PER_US = 12,
  parameter int W          = 4
) (
  input  logic       clk,
  input  logic       reset,
  wave_meter_if.master m
);

  localparam logic [1:0]   S_IDLE  = 2'd0;
  localparam logic [1:0]   S_HIGH  = 2'd1;
  localparam logic [1:0]   S_LOW   = 2'd2;
  localparam logic [7:0]   PSC_MAX = 8'(CLK_PER_US - 1);
  localparam logic [W-1:0] CNT_MAX = '1;

  logic [2:0]   sync_q,   sync_d;
  logic [1:0]   warm_q,   warm_d;
  logic [7:0]   psc_q,    psc_d;
  logic [W-1:0] cnt_q,    cnt_d;
  logic [1:0]   state_q,  state_d;
  logic [W-1:0] hi_hold_q, hi_hold_d;
  logic         hi_sat_q, hi_sat_d;
  logic [W-1:0] on_q,     on_d;
  logic [W-1:0] off_q,    off_d;
  logic         valid_q,  valid_d;
  logic         locked_q, locked_d;
  logic         ovf_q,    ovf_d;

  logic armed;
  logic rise;
  logic fall;
  logic edge_p;
  logic tick;
  logic cnt_sat;
  logic ovf_new;

  // edges are masked until the third stage holds a real sample,
  // so a wave already high at reset release is not seen as a rise
  always_comb begin
    sync_d  = {sync_q[1:0], m.wave_in};
    warm_d  = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    armed   = (warm_q == 2'd3);
    rise    = armed &  sync_q[1] & ~sync_q[2];
    fall    = armed & ~sync_q[1] &  sync_q[2];
    edge_p  = rise | fall;
    tick    = (psc_q == PSC_MAX) & ~edge_p;
    cnt_sat = (cnt_q == CNT_MAX);
  end

  always_comb begin
    psc_d = psc_q;
    cnt_d = cnt_q;
    if (edge_p) begin
      psc_d = 8'd1;
      cnt_d = '0;
    end else begin
      psc_d = (psc_q == PSC_MAX) ? 8'd0 : psc_q + 8'd1;
      if (tick && !cnt_sat)
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_hold_d = hi_hold_q;
    hi_sat_d  = hi_sat_q;
    on_d      = on_q;
    off_d     = off_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    ovf_new   = hi_sat_q | cnt_sat;
    if (state_q != S_IDLE && cnt_sat)
      locked_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rise)
          state_d = S_HIGH;
      end
      S_HIGH: begin
        if (fall) begin
          state_d   = S_LOW;
          hi_hold_d = cnt_q;
          hi_sat_d  = cnt_sat;
        end
      end
      S_LOW: begin
        if (rise) begin
          state_d  = S_HIGH;
          on_d     = hi_hold_q;
          off_d    = cnt_q;
          ovf_d    = ovf_new;
          valid_d  = 1'b1;
          locked_d = ~ovf_new;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      warm_q    <= '0;
      psc_q     <= '0;
      cnt_q     <= '0;
      state_q   <= S_IDLE;
      hi_hold_q <= '0;
      hi_sat_q  <= 1'b0;
      on_q      <= '0;
      off_q     <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      warm_q    <= warm_d;
      psc_q     <= psc_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      hi_hold_q <= hi_hold_d;
      hi_sat_q  <= hi_sat_d;
      on_q      <= on_d;
      off_q     <= off_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      ovf_q     <= ovf_d;
    end
  end

  assign m.on_us  = on_q;
  assign m.off_us = off_q;
  assign m.valid  = valid_q;
  assign m.locked = locked_q;
  assign m.ovf    = ovf_q;

endmodule

// File: tb/tb_wave_meter.sv
// Directed bench for wave_meter: a table of periods with
// hand-computed results plus stuck, reset and leading-high cases.
module tb_wave_meter;

  logic clk;
  logic reset;

  wave_meter_if #(.W(4)) m ();

  wave_meter #(
    .CLK_PER_US(12),
    .W         (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .m    (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int hi;
    int lo;
    int on;
    int off;
    int ovf;
    int lck;
  } vec_t;

  typedef struct {
    int     on;
    int     off;
    int     ovf;
    int     lck;
    longint stamp;
  } pub_t;

  pub_t   pq[$];
  longint cyc = 0;
  int     total = 0;
  int     passed = 0;
  longint last_stamp = 0;
  vec_t   vecs[8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (m.valid === 1'b1)
      pq.push_back('{int'(m.on_us), int'(m.off_us),
                     int'(m.ovf), int'(m.locked), cyc});

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else
      passed++;
  endtask

  task automatic phase(logic v, int n);
    m.wave_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pub(string name, int on, int off,
                            int ovf, int lck);
    pub_t p;
    chk({name, " count"}, pq.size(), 1);
    if (pq.size() > 0) begin
      p = pq.pop_front();
      chk({name, " on_us"},  p.on,  on);
      chk({name, " off_us"}, p.off, off);
      chk({name, " ovf"},    p.ovf, ovf);
      chk({name, " locked"}, p.lck, lck);
      last_stamp = p.stamp;
    end
    pq.delete();
  endtask

  task automatic expect_zero(string name);
    @(negedge clk);
    chk({name, " on_us"},  m.on_us,  0);
    chk({name, " off_us"}, m.off_us, 0);
    chk({name, " valid"},  m.valid,  0);
    chk({name, " locked"}, m.locked, 0);
    chk({name, " ovf"},    m.ovf,    0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{36,  60,  3, 5, 0, 1};
    vecs[1] = '{36,  60,  3, 5, 0, 1};
    vecs[2] = '{47,  48,  3, 4, 0, 1};
    vecs[3] = '{48,  48,  4, 4, 0, 1};
    vecs[4] = '{11,  12,  0, 1, 0, 1};
    vecs[5] = '{179, 12, 14, 1, 0, 1};
    vecs[6] = '{180, 12, 15, 1, 1, 0};
    vecs[7] = '{24,  24,  2, 2, 0, 1};

    reset     = 1'b1;
    m.wave_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_zero("reset");
    reset = 1'b0;
    phase(1'b0, 20);

    for (int i = 0; i < 8; i++) begin
      phase(1'b1, vecs[i].hi);
      if (i == 0) begin
        chk("first rise no valid", pq.size(), 0);
      end else begin
        if (i >= 2)
          chk($sformatf("period %0d spacing", i - 1),
              pq.size() > 0 ? pq[0].stamp - last_stamp : -1,
              vecs[i-1].hi + vecs[i-1].lo);
        expect_pub($sformatf("vec %0d", i - 1),
                   vecs[i-1].on, vecs[i-1].off,
                   vecs[i-1].ovf, vecs[i-1].lck);
      end
      phase(1'b0, vecs[i].lo);
    end

    phase(1'b1, 12);
    expect_pub("vec 7", 2, 2, 0, 1);

    phase(1'b1, 228);
    chk("stuck locked", m.locked, 0);
    chk("stuck on_us held", m.on_us, 2);
    chk("stuck off_us held", m.off_us, 2);
    chk("stuck no valid", pq.size(), 0);
    phase(1'b0, 24);
    phase(1'b1, 12);
    expect_pub("after stuck", 15, 2, 1, 0);
    phase(1'b1, 12);
    phase(1'b0, 24);
    phase(1'b1, 12);
    expect_pub("relock", 2, 2, 0, 1);

    phase(1'b1, 12);
    phase(1'b0, 10);
    reset = 1'b1;
    phase(1'b0, 1);
    expect_zero("reset in low");
    reset = 1'b0;
    phase(1'b0, 10);
    phase(1'b1, 24);
    phase(1'b0, 24);
    chk("post-reset no valid", pq.size(), 0);
    phase(1'b1, 12);
    expect_pub("post-reset", 2, 2, 0, 1);

    reset = 1'b1;
    phase(1'b1, 3);
    reset = 1'b0;
    phase(1'b1, 30);
    phase(1'b0, 24);
    phase(1'b1, 24);
    phase(1'b0, 36);
    chk("lead-high no valid", pq.size(), 0);
    phase(1'b1, 12);
    expect_pub("lead-high", 2, 3, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wave_meter.md
WAVE_METER -- requirements
Module: wave_meter

Interface
REQ-001 The parameter CLK_PER_US SHALL default to 12 and SHALL give the clk cycles per microsecond tick; legal range is 2..255.
REQ-002 The parameter W SHALL default to 4 and SHALL give the width of the measured counts in microseconds.
REQ-003 clk  input  1  system clock; every register SHALL be updated on its rising edge only.
REQ-004 reset  input  1  reset: reset reset, synchronous, active-high; clock clk.
REQ-005 wave_in  input  1  asynchronous square wave to measure (a wave generator output).
REQ-006 on_us  output  W  measured high time of the last complete period, in microseconds.
REQ-007 off_us  output  W  measured low time of the last complete period, in microseconds.
REQ-008 valid  output  1  one-cycle strobe; on_us, off_us and ovf are updated in the same cycle.
REQ-009 locked  output  1  level; high while the published measurement is in range and current.
REQ-010 ovf  output  1  the published measurement saturated in at least one phase.

Function
REQ-011 wave_in SHALL pass through a 2-flop synchronizer, followed by a third register for edge detection.
REQ-012 A rise pulse SHALL be asserted when the synchronized value is 1 and the delayed value is 0; a fall pulse SHALL be asserted for the opposite case; each pulse is 1 cycle long.
REQ-013 The prescaler SHALL load 1 on any rise or fall pulse; otherwise it SHALL increment and wrap from CLK_PER_US-1 to 0.
REQ-014 A tick SHALL be asserted in any cycle where the prescaler equals CLK_PER_US-1 and no edge pulse is present.
REQ-015 The phase counter (W bits) SHALL clear to 0 on any edge pulse, SHALL increment on each tick, and SHALL saturate at 2^W-1.
REQ-016 Given L clk cycles between consecutive edge pulses, the captured phase count SHALL equal min(floor(L/CLK_PER_US), 2^W-1).
REQ-017 The state machine SHALL have three states: IDLE, HIGH and LOW; reset SHALL force IDLE.
REQ-018 IDLE -> HIGH on a rise pulse; a fall pulse in IDLE SHALL be ignored.
REQ-019 HIGH -> LOW on a fall pulse, which SHALL latch the phase count into hi_hold and the high-phase saturation flag into hi_sat.
REQ-020 LOW -> HIGH on a rise pulse, which SHALL (a) set on_us <= hi_hold, (b) set off_us <= phase count, (c) set ovf <= hi_sat OR low-phase saturation, and (d) pulse valid in the next cycle together with the new values.
REQ-021 The first rise after IDLE SHALL NOT publish; the first valid SHALL require a full rise-fall-rise sequence.
REQ-022 locked SHALL go to 1 on a publish with ovf=0 and SHALL go to 0 on a publish with ovf=1.
REQ-023 locked SHALL also go to 0 in the cycle after the phase counter reaches 2^W-1 in HIGH or LOW, which marks the wave as stuck or out of range.
REQ-024 on_us and off_us SHALL hold their values between publishes; a saturation event SHALL NOT change them.
REQ-025 Latency: valid SHALL assert 3 clk cycles after the wave_in rising edge is first sampled (2 synchronizer stages + 1 output register).
REQ-026 Because both edges pass through the same synchronizer, the measured durations SHALL carry no synchronizer offset.

Reset
REQ-027 While reset is high, the block SHALL hold the following values, and they SHALL be valid in the cycle after reset is sampled: on_us=0, off_us=0, valid=0, locked=0, ovf=0, state=IDLE, prescaler=0, phase counter=0, hi_hold=0, hi_sat=0, and all synchronizer flops = 0.
REQ-028 A reset in HIGH or LOW SHALL abandon the measurement in progress; no valid SHALL be produced for the interrupted period.

Verification (CLK_PER_US=12, W=4)
REQ-029 Periodic wave, high 36 and low 60 cycles -> no valid at the first rise; valid at the second rise with on_us=3, off_us=5, ovf=0, locked=1; then exactly one valid every 96 cycles.
REQ-030 High 47 cycles, low 48 cycles -> on_us=3, off_us=4; then high 48 cycles -> on_us=4 at the next publish.
REQ-031 wave_in held high for 240 cycles after locking -> locked=0 once the count reaches 15, with on_us/off_us unchanged; then low 24 cycles and a rise -> valid with on_us=15, off_us=2, ovf=1, locked=0.
REQ-032 Following REQ-031, a clean period (high 24, low 24) -> valid with on_us=2, off_us=2, ovf=0, locked=1.
REQ-033 reset pulsed during LOW -> all outputs 0 in the next cycle; the next rise produces no valid; the first valid appears after a full rise-fall-rise sequence.
REQ-034 wave_in already high when reset is released -> the block stays in IDLE until a genuine 0->1 transition; the leading fall is ignored.
